conv_layer_ctrl: RTL

Sequencer for the 3x3 convolution datapath. It walks the output feature map in row, column, channel order and drives the shared `vld_i` into the four MAC kernels. It supplies the loop indices and padding flags that the IFM/weight tiling logic uses to build `din`/`win`. On the return path it counts MAC results per pixel, tells the partial-sum accumulator when to load and when to add, and pulses the per-pixel write enable toward activation/descaling and the output writers.

---
 rtl/conv_layer_ctrl_if.sv | 49 ++++
 rtl/conv_layer_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_ctrl_if.sv
// conv_layer_ctrl_if: bundle of the sequencer's control, index, return-path
// and statistics signals. The master side is the sequencer itself; the slave
// side is the surrounding datapath (tile source, MAC kernels, writers).
interface conv_layer_ctrl_if #(
    parameter int CNT_W = 16
);
    // Requests from the datapath
    logic             start;
    logic             in_rdy;
    logic             mac_vld;

    // Issue side
    logic             data_run;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] chn;
    logic             first_row;
    logic             last_row;
    logic             first_col;
    logic             last_col;

    // Return side
    logic             acc_load;
    logic             pixel_wr;
    logic [31:0]      pix_cnt;

    // Status and statistics
    logic             busy;
    logic             layer_done;
    logic             err;
    logic [31:0]      run_cycles;
    logic [31:0]      stall_cycles;

    modport master (
        input  start, in_rdy, mac_vld,
        output data_run, row, col, chn,
        output first_row, last_row, first_col, last_col,
        output acc_load, pixel_wr, pix_cnt,
        output busy, layer_done, err, run_cycles, stall_cycles
    );

    modport slave (
        output start, in_rdy, mac_vld,
        input  data_run, row, col, chn,
        input  first_row, last_row, first_col, last_col,
        input  acc_load, pixel_wr, pix_cnt,
        input  busy, layer_done, err, run_cycles, stall_cycles
    );
endinterface

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: walks the output feature map in row/column/channel order,
// issues one tile per cycle into the four lockstep MAC kernels, and tracks the
// returning MAC results to drive psum load/add and the per-pixel write pulse.
// Optional build macro: CONV_CTRL_STAT_EN enables the saturating run/stall
// cycle counters; without it both statistics outputs are tied to zero.
module conv_layer_ctrl #(
    parameter int IFM_WIDTH   = 256,
    parameter int IFM_HEIGHT  = 256,
    parameter int IFM_CHANNEL = 4,
    parameter int ROW_GAP     = 100,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rstn,
    conv_layer_ctrl_if.master ctrl_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int               OST_W    = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IFM_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IFM_HEIGHT - 1);
    localparam logic [CNT_W-1:0] LAST_CHN = CNT_W'(IFM_CHANNEL - 1);
    // The gap counter is loaded with ROW_GAP-1 and the row starts when it hits 0.
    localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] chn_q, chn_d;
    logic             first_row_q, first_row_d;
    logic             last_row_q, last_row_d;
    logic             first_col_q, first_col_d;
    logic             last_col_q, last_col_d;
    logic [OST_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] out_chn_q, out_chn_d;
    logic             pixel_wr_q, pixel_wr_d;
    logic [31:0]      pix_cnt_q, pix_cnt_d;
    logic             err_q, err_d;

    logic issue;
    logic start_acc;
    logic ret_orphan;

    assign issue      = (state_q == S_RUN) && ctrl_if.in_rdy;
    assign start_acc  = (state_q == S_IDLE) && ctrl_if.start;
    // A result with nothing outstanding cannot belong to any issued tile.
    assign ret_orphan = ctrl_if.mac_vld && (outst_q == '0);

    // Outstanding-issue bookkeeping and return-path next state.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path through the block can infer a latch.
        outst_d    = outst_q;
        out_chn_d  = out_chn_q;
        pixel_wr_d = 1'b0;
        pix_cnt_d  = pix_cnt_q + 32'(pixel_wr_q);
        err_d      = err_q;

        // An issue and a retirement on the same cycle cancel out.
        if (issue && !ctrl_if.mac_vld) begin
            outst_d = outst_q + OST_W'(1);
        end else if (!issue && ctrl_if.mac_vld && !ret_orphan) begin
            outst_d = outst_q - OST_W'(1);
        end

        if (ctrl_if.mac_vld) begin
            pixel_wr_d = (out_chn_q == LAST_CHN);
            out_chn_d  = (out_chn_q == LAST_CHN) ? '0 : out_chn_q + CNT_W'(1);
        end

        if (ret_orphan) begin
            err_d = 1'b1;
        end

        if (start_acc) begin
            out_chn_d = '0;
            pix_cnt_d = '0;
            err_d     = 1'b0;
        end
    end

    // Layer FSM: next state, loop indices and padding flags.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        row_d   = row_q;
        col_d   = col_q;
        chn_d   = chn_q;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_if.start) begin
                    row_d = '0;
                    col_d = '0;
                    chn_d = '0;
                    if (ROW_GAP == 0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end

            S_RUN: begin
                if (ctrl_if.in_rdy) begin
                    if (chn_q != LAST_CHN) begin
                        chn_d = chn_q + CNT_W'(1);
                    end else begin
                        chn_d = '0;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + CNT_W'(1);
                        end else begin
                            col_d = '0;
                            if (row_q == LAST_ROW) begin
                                // Nothing left in flight: skip the drain wait.
                                state_d = (outst_d == '0) ? S_DONE : S_DRAIN;
                            end else begin
                                row_d = row_q + CNT_W'(1);
                                if (ROW_GAP != 0) begin
                                    state_d = S_GAP;
                                    gap_d   = GAP_INIT;
                                end
                            end
                        end
                    end
                end
            end

            S_DRAIN: begin
                // Look at the post-retirement count so layer_done follows the
                // last result by one cycle.
                if (outst_d == '0) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags track the indices that will be presented next cycle and are
        // forced low while idle.
        first_row_d = (state_d != S_IDLE) && (row_d == '0);
        last_row_d  = (state_d != S_IDLE) && (row_d == LAST_ROW);
        first_col_d = (state_d != S_IDLE) && (col_d == '0);
        last_col_d  = (state_d != S_IDLE) && (col_d == LAST_COL);
    end

    // State, indices, flags and return-path registers.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: asynchronous active-low reset; sequential state is only ever
        // updated with non-blocking assignments so all registers see the same
        // pre-edge values.
        if (!rstn) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            chn_q       <= '0;
            first_row_q <= 1'b0;
            last_row_q  <= 1'b0;
            first_col_q <= 1'b0;
            last_col_q  <= 1'b0;
            outst_q     <= '0;
            out_chn_q   <= '0;
            pixel_wr_q  <= 1'b0;
            pix_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            row_q       <= row_d;
            col_q       <= col_d;
            chn_q       <= chn_d;
            first_row_q <= first_row_d;
            last_row_q  <= last_row_d;
            first_col_q <= first_col_d;
            last_col_q  <= last_col_d;
            outst_q     <= outst_d;
            out_chn_q   <= out_chn_d;
            pixel_wr_q  <= pixel_wr_d;
            pix_cnt_q   <= pix_cnt_d;
            err_q       <= err_d;
        end
    end

`ifdef CONV_CTRL_STAT_EN
    logic [31:0] run_cyc_q, run_cyc_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;

    // Saturating statistics over RUN cycles, cleared by an accepted start.
    always_comb begin
        run_cyc_d   = run_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (start_acc) begin
            run_cyc_d   = '0;
            stall_cyc_d = '0;
        end else if (state_q == S_RUN) begin
            if (ctrl_if.in_rdy && (run_cyc_q != '1)) begin
                run_cyc_d = run_cyc_q + 32'd1;
            end
            if (!ctrl_if.in_rdy && (stall_cyc_q != '1)) begin
                stall_cyc_d = stall_cyc_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cyc_q   <= '0;
            stall_cyc_q <= '0;
        end else begin
            run_cyc_q   <= run_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign ctrl_if.run_cycles   = run_cyc_q;
    assign ctrl_if.stall_cycles = stall_cyc_q;
`else
    assign ctrl_if.run_cycles   = '0;
    assign ctrl_if.stall_cycles = '0;
`endif

    assign ctrl_if.data_run   = issue;
    assign ctrl_if.row        = row_q;
    assign ctrl_if.col        = col_q;
    assign ctrl_if.chn        = chn_q;
    assign ctrl_if.first_row  = first_row_q;
    assign ctrl_if.last_row   = last_row_q;
    assign ctrl_if.first_col  = first_col_q;
    assign ctrl_if.last_col   = last_col_q;
    assign ctrl_if.acc_load   = ctrl_if.mac_vld && (out_chn_q == '0);
    assign ctrl_if.pixel_wr   = pixel_wr_q;
    assign ctrl_if.pix_cnt    = pix_cnt_q;
    assign ctrl_if.busy       = (state_q != S_IDLE);
    assign ctrl_if.layer_done = (state_q == S_DONE);
    assign ctrl_if.err        = err_q;

endmodule
